// File: rtl/rfid_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rfid_timing_pkg
// Description : Shared timing definitions for the tag interval arbiter:
//               counter width, saturation value, arbiter state encoding and
//               the standard interval counts loaded by the requesters.
// Revision    : 1.0 - initial release
// ============================================================================
package rfid_timing_pkg;

   // Width of the shared interval counter and of every requester limit.
   localparam int c_CNT_W   = 16;

   // The external counter stops at this value; its overflow flag is count > c_SAT_MAX-1.
   localparam int c_SAT_MAX = 2501;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   // Standard tag intervals, in clk cycles, loaded by the requesters.
   localparam logic [c_CNT_W-1:0] c_T1_CNT         = 16'd64;
   localparam logic [c_CNT_W-1:0] c_T2_CNT         = 16'd60;
   localparam logic [c_CNT_W-1:0] c_RX_TIMEOUT_CNT = 16'd2400;

endpackage
`default_nettype wire

// File: rtl/rfid_timer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rfid_timer_arbiter_if
// Description : Requester-side bundle of the interval arbiter: level requests,
//               packed limits, one-hot grant, done pulses and busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface rfid_timer_arbiter_if
   import rfid_timing_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int CNT_W = c_CNT_W
);
   logic [NREQ-1:0]       req;
   logic [NREQ*CNT_W-1:0] req_limit;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic                  busy;

   // Requester side drives requests and limits.
   modport master (
      output req,
      output req_limit,
      input  grant,
      input  done,
      input  busy
   );

   // Arbiter side answers with grant, done and busy.
   modport slave (
      input  req,
      input  req_limit,
      output grant,
      output done,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/rfid_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rfid_rr_pick
// Description : Combinational round-robin picker. Selects the first active
//               request at or after position last+1 (modulo NREQ).
// Revision    : 1.0 - initial release
// ============================================================================
module rfid_rr_pick #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]         i_req,
   input  logic [$clog2(NREQ)-1:0] i_last,
   output logic [NREQ-1:0]         o_grant,
   output logic [$clog2(NREQ)-1:0] o_idx,
   output logic                    o_valid
);
   localparam int c_IDX_W = $clog2(NREQ);

   // Walk the positions in rotating priority order; the first hit wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int m = 0; m < NREQ; m++) begin
            if (!o_valid && (m == ((int'(i_last) + k) % NREQ)) && i_req[m]) begin
               o_valid    = 1'b1;
               o_grant[m] = 1'b1;
               o_idx      = c_IDX_W'(m);
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/rfid_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rfid_timer_arbiter
// Description : Shares one external saturating interval counter among NREQ
//               requesters. Round-robin arbitration, limit latch with clamp,
//               counter reset/enable sequencing and a one-cycle done pulse.
//               Every output is taken straight from a flop so ctr_reset is
//               glitch-free for the counter's asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rfid_timer_arbiter
   import rfid_timing_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int CNT_W   = c_CNT_W,
   parameter int SAT_MAX = c_SAT_MAX
) (
   input  logic                 clk,
   input  logic                 reset,
   rfid_timer_arbiter_if.slave  bus,
   output logic                 ctr_reset,
   output logic                 ctr_enable,
   input  logic [CNT_W-1:0]     ctr_count,
   input  logic                 ctr_overflow
);
   localparam int                   c_IDX_W     = $clog2(NREQ);
   localparam logic [c_IDX_W-1:0]   c_LAST_RST  = c_IDX_W'(NREQ - 1);
   localparam logic [CNT_W-1:0]     c_SAT_LIMIT = CNT_W'(SAT_MAX);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [c_IDX_W-1:0]  r_last;
   logic [c_IDX_W-1:0]  w_last_nxt;
   logic [c_IDX_W-1:0]  r_gidx;
   logic [c_IDX_W-1:0]  w_gidx_nxt;
   logic [CNT_W-1:0]    r_limit;
   logic [CNT_W-1:0]    w_limit_nxt;
   logic [NREQ-1:0]     r_grant;
   logic [NREQ-1:0]     w_grant_nxt;
   logic [NREQ-1:0]     r_done;
   logic [NREQ-1:0]     w_done_nxt;
   logic                r_busy;
   logic                w_busy_nxt;
   logic                r_ctr_reset;
   logic                w_ctr_reset_nxt;
   logic                r_ctr_enable;
   logic                w_ctr_enable_nxt;

   logic [NREQ-1:0]     w_pick_grant;
   logic [c_IDX_W-1:0]  w_pick_idx;
   logic                w_pick_valid;
   logic [CNT_W-1:0]    w_limits [NREQ];
   logic [CNT_W-1:0]    w_limit_sel;
   logic [CNT_W-1:0]    w_limit_clamped;
   logic                w_expired;
   logic                w_req_held;

   rfid_rr_pick #(
      .NREQ    (NREQ)
   ) u_pick (
      .i_req   (bus.req),
      .i_last  (r_last),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_limit_slice
         assign w_limits[i] = bus.req_limit[i*CNT_W +: CNT_W];
      end
   endgenerate

   // Limits beyond the saturation point could never be reached, so clamp them.
   assign w_limit_sel     = w_limits[w_pick_idx];
   assign w_limit_clamped = (w_limit_sel > c_SAT_LIMIT) ? c_SAT_LIMIT : w_limit_sel;
   assign w_expired       = (ctr_count >= r_limit) || ctr_overflow;
   assign w_req_held      = bus.req[r_gidx];

   assign bus.grant  = r_grant;
   assign bus.done   = r_done;
   assign bus.busy   = r_busy;
   assign ctr_reset  = r_ctr_reset;
   assign ctr_enable = r_ctr_enable;

   // State and output registers; reset holds the counter cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last       <= c_LAST_RST;
         r_gidx       <= '0;
         r_limit      <= '0;
         r_grant      <= '0;
         r_done       <= '0;
         r_busy       <= 1'b0;
         r_ctr_reset  <= 1'b1;
         r_ctr_enable <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last       <= w_last_nxt;
         r_gidx       <= w_gidx_nxt;
         r_limit      <= w_limit_nxt;
         r_grant      <= w_grant_nxt;
         r_done       <= w_done_nxt;
         r_busy       <= w_busy_nxt;
         r_ctr_reset  <= w_ctr_reset_nxt;
         r_ctr_enable <= w_ctr_enable_nxt;
      end
   end

   // Next state and next registered outputs; expiry beats a dropped request.
   always_comb begin
      w_state_nxt      = r_state;
      w_last_nxt       = r_last;
      w_gidx_nxt       = r_gidx;
      w_limit_nxt      = r_limit;
      w_grant_nxt      = r_grant;
      w_done_nxt       = '0;
      w_busy_nxt       = r_busy;
      w_ctr_reset_nxt  = r_ctr_reset;
      w_ctr_enable_nxt = r_ctr_enable;
      case (r_state)
         ST_IDLE: begin
            w_grant_nxt      = '0;
            w_busy_nxt       = 1'b0;
            w_ctr_reset_nxt  = 1'b1;
            w_ctr_enable_nxt = 1'b0;
            if (w_pick_valid) begin
               w_state_nxt      = ST_RUN;
               w_gidx_nxt       = w_pick_idx;
               w_limit_nxt      = w_limit_clamped;
               w_grant_nxt      = w_pick_grant;
               w_busy_nxt       = 1'b1;
               w_ctr_reset_nxt  = 1'b0;
               w_ctr_enable_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_expired) begin
               w_state_nxt      = ST_DONE;
               w_done_nxt       = r_grant;
               w_ctr_reset_nxt  = 1'b1;
               w_ctr_enable_nxt = 1'b0;
            end else if (!w_req_held) begin
               w_state_nxt      = ST_IDLE;
               w_grant_nxt      = '0;
               w_busy_nxt       = 1'b0;
               w_ctr_reset_nxt  = 1'b1;
               w_ctr_enable_nxt = 1'b0;
            end
         end
         ST_DONE: begin
            w_state_nxt      = ST_IDLE;
            w_last_nxt       = r_gidx;
            w_grant_nxt      = '0;
            w_busy_nxt       = 1'b0;
            w_ctr_reset_nxt  = 1'b1;
            w_ctr_enable_nxt = 1'b0;
         end
         default: begin
            w_state_nxt      = ST_IDLE;
            w_grant_nxt      = '0;
            w_busy_nxt       = 1'b0;
            w_ctr_reset_nxt  = 1'b1;
            w_ctr_enable_nxt = 1'b0;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_rfid_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rfid_timer_arbiter
// Description : Self-checking bench for rfid_timer_arbiter. Models the
//               external saturating counter, predicts every output per cycle
//               from a grant/deadline timeline, and pins the model with
//               hand-computed latencies for the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rfid_timer_arbiter;
   localparam int NREQ    = 3;
   localparam int CNT_W   = 16;
   localparam int SAT_MAX = 2501;

   logic             clk   = 1'b0;
   logic             reset = 1'b1;
   logic             ctr_reset;
   logic             ctr_enable;
   logic             ctr_overflow;
   logic [CNT_W-1:0] ctr_count = '0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model timeline: current owner (-1 = none), first grant cycle, effective limit.
   int m_owner = -1;
   int m_gcyc  = 0;
   int m_lim   = 0;
   int m_last  = NREQ - 1;

   // Event logs: grant rises and done pulses with their cycle numbers.
   int gq_idx[$];
   int gq_cyc[$];
   int dq_idx[$];
   int dq_cyc[$];
   logic [NREQ-1:0] prev_grant = '0;

   rfid_timer_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

   rfid_timer_arbiter #(
      .NREQ         (NREQ),
      .CNT_W        (CNT_W),
      .SAT_MAX      (SAT_MAX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .ctr_reset    (ctr_reset),
      .ctr_enable   (ctr_enable),
      .ctr_count    (ctr_count),
      .ctr_overflow (ctr_overflow)
   );

   always #5 clk = ~clk;

   // External saturating counter with asynchronous clear.
   always @(posedge clk or posedge ctr_reset) begin
      if (ctr_reset)
         ctr_count <= '0;
      else if (ctr_enable && (ctr_count < CNT_W'(SAT_MAX)))
         ctr_count <= ctr_count + 1'b1;
   end
   assign ctr_overflow = (ctr_count > 16'd2500);

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int oh_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   // Per-cycle compare against the timeline model, then advance the model.
   initial begin
      logic [NREQ-1:0] e_grant;
      logic [NREQ-1:0] e_done;
      logic            e_busy;
      logic            e_rst;
      logic            e_en;
      int              e_cnt;
      int              done_c;
      int              lim_raw;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.grant != '0 && prev_grant == '0) begin
            gq_idx.push_back(oh_idx(bus.grant));
            gq_cyc.push_back(cyc);
         end
         prev_grant = bus.grant;
         if (bus.done != '0) begin
            dq_idx.push_back(oh_idx(bus.done));
            dq_cyc.push_back(cyc);
         end

         if (reset) begin
            m_owner = -1;
            m_last  = NREQ - 1;
         end

         e_grant = '0;
         e_done  = '0;
         e_busy  = 1'b0;
         e_rst   = 1'b1;
         e_en    = 1'b0;
         e_cnt   = 0;
         done_c  = m_gcyc + 1 + m_lim;
         if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_busy = 1'b1;
            if (cyc < done_c) begin
               e_rst = 1'b0;
               e_en  = 1'b1;
               e_cnt = cyc - m_gcyc;
            end else begin
               e_done = e_grant;
            end
         end
         chk("grant", bus.grant, e_grant);
         chk("done", bus.done, e_done);
         chk("busy", bus.busy, e_busy);
         chk("ctr_reset", ctr_reset, e_rst);
         chk("ctr_enable", ctr_enable, e_en);
         chk("ctr_count", ctr_count, e_cnt);

         if (!reset) begin
            if (m_owner < 0) begin
               for (int k = 1; k <= NREQ; k++) begin
                  int j;
                  j = (m_last + k) % NREQ;
                  if (m_owner < 0 && bus.req[j]) begin
                     m_owner = j;
                     m_gcyc  = cyc + 1;
                     lim_raw = int'(bus.req_limit[j*CNT_W +: CNT_W]);
                     m_lim   = (lim_raw > SAT_MAX) ? SAT_MAX : lim_raw;
                  end
               end
            end else if (cyc == done_c) begin
               m_last  = m_owner;
               m_owner = -1;
            end else if (!bus.req[m_owner] && cyc != done_c - 1) begin
               m_owner = -1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_limit(input int i, input int v);
      bus.req_limit[i*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   // Returns the cycle in which done[idx] is high, plus the peak count and overflow seen.
   task automatic wait_done(input int idx, input int budget, output int when,
                            output int maxcnt, output bit ovf);
      bit found = 1'b0;
      when = -1;
      maxcnt = 0;
      ovf = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         tick();
         if (int'(ctr_count) > maxcnt) maxcnt = int'(ctr_count);
         if (ctr_overflow) ovf = 1'b1;
         if (bus.done[idx]) begin
            found = 1'b1;
            when  = cyc + 1;
         end
      end
      chk($sformatf("done%0d_seen", idx), found, 1);
   endtask

   task automatic wait_grant(input int idx, input int budget, output int when);
      bit found = 1'b0;
      when = -1;
      for (int i = 0; i < budget && !found; i++) begin
         tick();
         if (bus.grant[idx]) begin
            found = 1'b1;
            when  = cyc + 1;
         end
      end
      chk($sformatf("grant%0d_seen", idx), found, 1);
   endtask

   initial begin
      int n, w, mx, g, x, cnt2;
      bit ov, found;
      bus.req       = '0;
      bus.req_limit = '0;

      // Reset state.
      repeat (3) tick();
      chk("rst_grant", bus.grant, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ctr_reset", ctr_reset, 1);
      chk("rst_ctr_enable", ctr_enable, 0);
      reset = 1'b0;
      tick();

      // Round-robin with all three held, limit 2: order 0,1,2,0.
      for (int i = 0; i < NREQ; i++) set_limit(i, 2);
      gq_idx.delete(); gq_cyc.delete(); dq_idx.delete(); dq_cyc.delete();
      bus.req = 3'b111;
      wait_done(0, 20, w, mx, ov);
      wait_done(1, 20, w, mx, ov);
      wait_done(2, 20, w, mx, ov);
      wait_done(0, 20, w, mx, ov);
      bus.req = '0;
      chk("rr_grants", gq_idx.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("rr_order%0d", i), (gq_idx.size() > i) ? gq_idx[i] : -1, (i == 3) ? 0 : i);
      // grant -> grant: limit+1 run cycles, done, one idle cycle.
      chk("rr_spacing", (gq_cyc.size() > 1) ? gq_cyc[1] - gq_cyc[0] : -1, 5);
      chk("rr_done_lat", (dq_cyc.size() > 0 && gq_cyc.size() > 0) ? dq_cyc[0] - gq_cyc[0] : -1, 3);
      repeat (2) tick();

      // Single request, limit 5: done at N+7, counter peaks at 5.
      set_limit(0, 5);
      bus.req = 3'b001;
      n = cyc + 1;
      wait_done(0, 20, w, mx, ov);
      bus.req = '0;
      chk("single_done_lat", w - n, 7);
      chk("single_peak", mx, 5);
      repeat (2) tick();

      // Clamp to saturation: limit 0xFFFF behaves like 2501.
      set_limit(1, 16'hFFFF);
      bus.req = 3'b010;
      n = cyc + 1;
      wait_done(1, 2600, w, mx, ov);
      bus.req = '0;
      chk("clamp_done_lat", w - n, 2 + SAT_MAX);
      chk("clamp_peak", mx, SAT_MAX);
      chk("clamp_ovf_seen", ov, 1);
      repeat (2) tick();

      // Abort: requester 2 drops at count 40, pending requester 0 follows.
      set_limit(0, 3);
      set_limit(2, 100);
      gq_idx.delete(); gq_cyc.delete(); dq_idx.delete(); dq_cyc.delete();
      bus.req = 3'b101;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         tick();
         if (bus.grant[2] && ctr_count == 16'd40) found = 1'b1;
      end
      chk("abort_reach40", found, 1);
      x = cyc + 1;
      bus.req = 3'b001;
      wait_grant(0, 10, g);
      chk("abort_regrant_lat", g - x, 2);
      chk("abort_regrant_cnt", ctr_count, 0);
      wait_done(0, 20, w, mx, ov);
      bus.req = '0;
      chk("abort_first_owner", (gq_idx.size() > 0) ? gq_idx[0] : -1, 2);
      cnt2 = 0;
      foreach (dq_idx[i]) if (dq_idx[i] == 2) cnt2++;
      chk("abort_no_done2", cnt2, 0);
      repeat (2) tick();

      // Zero limit: done at N+2.
      set_limit(1, 0);
      bus.req = 3'b010;
      n = cyc + 1;
      wait_done(1, 10, w, mx, ov);
      bus.req = '0;
      chk("zero_done_lat", w - n, 2);
      repeat (2) tick();

      // Request dropped in the expiry cycle (N+5 for limit 4): done still at N+6.
      set_limit(2, 4);
      bus.req = 3'b100;
      n = cyc + 1;
      while (cyc + 1 < n + 5) tick();
      bus.req = '0;
      wait_done(2, 10, w, mx, ov);
      chk("dropexp_done_lat", w - n, 6);
      repeat (2) tick();

      // Asynchronous reset at count 37, then requester 0 wins first.
      set_limit(0, 100);
      bus.req = 3'b001;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (bus.grant[0] && ctr_count == 16'd37) found = 1'b1;
      end
      chk("rst_reach37", found, 1);
      reset = 1'b1;
      #1;
      chk("midrst_grant", bus.grant, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_ctr_reset", ctr_reset, 1);
      chk("midrst_ctr_enable", ctr_enable, 0);
      chk("midrst_count", ctr_count, 0);
      tick();
      tick();
      for (int i = 0; i < NREQ; i++) set_limit(i, 1);
      bus.req = 3'b111;
      gq_idx.delete(); gq_cyc.delete();
      reset = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (bus.grant != '0) found = 1'b1;
      end
      chk("postrst_grant_seen", found, 1);
      chk("postrst_first", oh_idx(bus.grant), 0);
      wait_done(0, 10, w, mx, ov);
      bus.req = '0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
